// File: rtl/hci_streamer_sequencer.sv
// -----------------------------------------------------------------------------
// hci_streamer_sequencer
//   Queues streamer jobs (address-generator configurations) in a small FIFO
//   and hands them one at a time to an HCI streamer. Each job goes through
//   IDLE (issue) -> WORKING (wait for done) -> DONE (one-cycle completion).
//
//   The struct-typed ports are carried as packed vectors so the block stands
//   alone; field order matches a packed struct (first field = MSBs):
//     ctrl_o  = {req_start, addressgen_ctrl[CFG_W-1:0]}
//     flags_i = {ready_start, done, addressgen_flags[AGF_W-1:0]}
//     state_o : 0 = IDLE, 1 = WORKING, 2 = DONE
//
// Ports
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clear_i         synchronous clear (wins over push/issue/done)
//   job_valid_i     push request, job_cfg_i = configuration of that job
//   job_ready_o     FIFO not full
//   ctrl_o          streamer control
//   flags_i         streamer flags (addressgen_flags ignored)
//   state_o         sequencer state
//   evt_done_o      one-cycle pulse per completed job
//   jobs_pending_o  FIFO occupancy
//   jobs_done_o     completed-job counter (wraps)
// -----------------------------------------------------------------------------
module hci_streamer_sequencer #(
   parameter int JOB_DEPTH = 2,
   parameter int CNT_W     = 16,
   parameter int CFG_W     = 32,
   parameter int AGF_W     = 8,
   localparam int PW       = (JOB_DEPTH > 1) ? $clog2(JOB_DEPTH) : 1,
   localparam int OCC_W    = $clog2(JOB_DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               clear_i,
   input  logic               job_valid_i,
   output logic               job_ready_o,
   input  logic [CFG_W-1:0]   job_cfg_i,
   output logic [CFG_W:0]     ctrl_o,
   input  logic [AGF_W+1:0]   flags_i,
   output logic [1:0]         state_o,
   output logic               evt_done_o,
   output logic [OCC_W-1:0]   jobs_pending_o,
   output logic [CNT_W-1:0]   jobs_done_o
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WORKING = 2'd1,
      ST_DONE    = 2'd2
   } state_t;

   state_t             r_state, w_state_nxt;
   logic [CFG_W-1:0]   r_mem [JOB_DEPTH];
   logic [PW-1:0]      r_wptr, r_rptr;
   logic [OCC_W-1:0]   r_cnt;
   logic [CFG_W-1:0]   r_cfg;
   logic [CNT_W-1:0]   r_done_cnt;

   logic               w_empty, w_full, w_push, w_pop;
   logic               w_req_start, w_ready_start, w_done;
   logic [CFG_W-1:0]   w_cfg_out;

   assign w_ready_start = flags_i[AGF_W+1];
   assign w_done        = flags_i[AGF_W];

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == OCC_W'(JOB_DEPTH));
   // no bypass: a full FIFO refuses pushes even while popping
   assign w_push  = job_valid_i && !w_full;
   assign w_pop   = w_req_start;

   // ---------------- FSM next state / outputs ----------------
   always_comb begin
      w_state_nxt = r_state;
      w_req_start = 1'b0;
      w_cfg_out   = r_cfg;
      unique case (r_state)
         ST_IDLE: begin
            w_cfg_out   = w_empty ? '0 : r_mem[r_rptr];
            w_req_start = !w_empty && w_ready_start && !clear_i;
            if (w_req_start) w_state_nxt = ST_WORKING;
         end
         ST_WORKING: if (w_done) w_state_nxt = ST_DONE;
         ST_DONE:    w_state_nxt = ST_IDLE;
         default:    w_state_nxt = ST_IDLE;
      endcase
      if (clear_i) w_state_nxt = ST_IDLE;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= ST_IDLE;
      else         r_state <= w_state_nxt;
   end

   // ---------------- job FIFO ----------------
   // storage needs no reset: the head is masked to zero while empty
   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) r_mem[r_wptr] <= job_cfg_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else if (clear_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= r_rptr + PW'(1);
         r_cnt <= r_cnt + OCC_W'(w_push) - OCC_W'(w_pop);
      end
   end

   // ---------------- in-flight config and completion counter ----------------
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_cfg      <= '0;
         r_done_cnt <= '0;
      end else if (clear_i) begin
         r_cfg      <= '0;
         r_done_cnt <= '0;
      end else begin
         if (w_req_start)         r_cfg      <= r_mem[r_rptr];
         if (r_state == ST_DONE)  r_done_cnt <= r_done_cnt + CNT_W'(1);
      end
   end

   assign ctrl_o         = {w_req_start, w_cfg_out};
   assign state_o        = r_state;
   assign evt_done_o     = (r_state == ST_DONE);
   assign job_ready_o    = !w_full;
   assign jobs_pending_o = r_cnt;
   assign jobs_done_o    = r_done_cnt;

endmodule

// File: tb/tb_hci_streamer_sequencer.sv
module tb_hci_streamer_sequencer;
   localparam int DEPTH = 2;
   localparam int CNT_W = 2;
   localparam int CFG_W = 32;
   localparam int AGF_W = 8;
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic               clk = 1'b0;
   logic               rst_ni;
   logic               clear_i;
   logic               job_valid_i;
   logic               job_ready_o;
   logic [CFG_W-1:0]   job_cfg_i;
   logic [CFG_W:0]     ctrl_o;
   logic [AGF_W+1:0]   flags_i;
   logic [1:0]         state_o;
   logic               evt_done_o;
   logic [OCC_W-1:0]   jobs_pending_o;
   logic [CNT_W-1:0]   jobs_done_o;

   always #5 clk = ~clk;

   hci_streamer_sequencer #(
      .JOB_DEPTH(DEPTH), .CNT_W(CNT_W), .CFG_W(CFG_W), .AGF_W(AGF_W)
   ) dut (
      .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o), .job_cfg_i(job_cfg_i),
      .ctrl_o(ctrl_o), .flags_i(flags_i), .state_o(state_o),
      .evt_done_o(evt_done_o), .jobs_pending_o(jobs_pending_o), .jobs_done_o(jobs_done_o)
   );

   int nvec = 0;
   int nerr = 0;

   // reference model: pending jobs, the job being run, and where it is in its life
   logic [CFG_W-1:0] q[$];
   logic [CFG_W-1:0] inflight;
   bit               running;    // issued, waiting for done
   bit               finishing;  // completion cycle
   int               completed;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      inflight  = '0;
      running   = 1'b0;
      finishing = 1'b0;
      completed = 0;
   endtask

   task automatic check_idle_cleared(input string tag);
      chk({tag, "_state"},   64'(state_o),        64'd0);
      chk({tag, "_pending"}, 64'(jobs_pending_o), 64'd0);
      chk({tag, "_done"},    64'(jobs_done_o),    64'd0);
      chk({tag, "_evt"},     64'(evt_done_o),     64'd0);
      chk({tag, "_ctrl"},    64'(ctrl_o),         64'd0);
      chk({tag, "_ready"},   64'(job_ready_o),    64'd1);
   endtask

   // one clock cycle: drive, check combinational/registered outputs, advance model
   task automatic cycle(input logic v, input logic [CFG_W-1:0] c,
                        input logic rs, input logic dn, input logic clr);
      bit               e_ready, e_req;
      logic [CFG_W-1:0] e_cfg;
      int               e_state;
      @(negedge clk);
      job_valid_i = v;
      job_cfg_i   = c;
      flags_i     = {rs, dn, AGF_W'($urandom)};
      clear_i     = clr;
      #1;
      e_ready = (q.size() < DEPTH);
      e_req   = !running && !finishing && (q.size() > 0) && rs && !clr;
      if (running || finishing) e_cfg = inflight;
      else                      e_cfg = (q.size() > 0) ? q[0] : '0;
      e_state = finishing ? 2 : (running ? 1 : 0);
      chk("ready",     64'(job_ready_o),    64'(e_ready));
      chk("req_start", 64'(ctrl_o[CFG_W]),  64'(e_req));
      chk("agen_cfg",  64'(ctrl_o[CFG_W-1:0]), 64'(e_cfg));
      chk("state",     64'(state_o),        64'(e_state));
      chk("evt_done",  64'(evt_done_o),     64'(finishing));
      chk("pending",   64'(jobs_pending_o), 64'(q.size()));
      chk("jobs_done", 64'(jobs_done_o),    64'(completed % (1 << CNT_W)));
      if (clr) model_reset();
      else begin
         if (finishing) begin
            completed++;
            finishing = 1'b0;
         end else if (running && dn) begin
            running   = 1'b0;
            finishing = 1'b1;
         end
         if (e_req) begin
            inflight = q.pop_front();
            running  = 1'b1;
         end
         if (v && e_ready) q.push_back(c);
      end
   endtask

   initial begin
      logic [CFG_W-1:0] A, B;
      A = 32'hA5A5_0001;
      B = 32'h5A5A_0002;
      rst_ni = 1'b0; clear_i = 1'b0; job_valid_i = 1'b0; job_cfg_i = '0; flags_i = '0;
      model_reset();
      repeat (2) @(negedge clk);
      #1 check_idle_cleared("reset");
      rst_ni = 1'b1;

      // single job: issue next cycle, done after 5 working cycles
      cycle(1, A, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);               // req_start with cfg A
      repeat (4) cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 1, 0);               // done
      cycle(0, 0, 1, 0, 0);               // DONE, jobs_done -> 1
      cycle(0, 0, 1, 0, 0);               // IDLE

      // full FIFO, third push refused, then drain in order
      cycle(1, A, 0, 0, 0);
      cycle(1, B, 0, 0, 0);
      cycle(1, 32'hDEAD_BEEF, 0, 0, 0);   // refused
      cycle(0, 0, 1, 0, 0);               // issue A
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 1, 0);
      cycle(0, 0, 1, 0, 0);               // DONE
      cycle(0, 0, 1, 0, 0);               // issue B
      cycle(0, 0, 1, 1, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 1, 0, 0);

      // stall: job pending, ready_start low
      cycle(1, A, 0, 0, 0);
      repeat (10) cycle(0, 0, 0, 0, 0);

      // spurious done: in IDLE and in the issue cycle
      cycle(0, 0, 0, 1, 0);
      cycle(0, 0, 1, 1, 0);               // issue with done high
      cycle(0, 0, 1, 0, 0);               // still WORKING
      cycle(0, 0, 1, 1, 0);
      cycle(0, 0, 1, 0, 0);
      cycle(0, 0, 0, 1, 0);               // done in IDLE ignored

      // mid-job clear with one job queued
      cycle(1, A, 1, 0, 0);
      cycle(1, B, 1, 0, 0);               // issue A, push B
      cycle(0, 0, 1, 0, 1);               // clear while WORKING
      cycle(0, 0, 0, 0, 0);               // back to IDLE, empty

      // mid-job async reset with one job queued
      cycle(1, A, 1, 0, 0);
      cycle(1, B, 1, 0, 0);
      @(negedge clk);
      job_valid_i = 1'b0; flags_i = '0; #2;
      rst_ni = 1'b0;
      #1 check_idle_cleared("async_rst");
      model_reset();
      @(negedge clk); rst_ni = 1'b1;

      // counter wrap: 4 jobs -> 1, 2, 3, 0
      for (int j = 0; j < 4; j++) begin
         cycle(1, 32'(j + 100), 1, 0, 0);
         cycle(0, 0, 1, 0, 0);
         cycle(0, 0, 1, 1, 0);
         cycle(0, 0, 1, 0, 0);
         cycle(0, 0, 1, 0, 0);
      end
      chk("wrap_zero", 64'(jobs_done_o), 64'd0);

      // randomized traffic
      for (int n = 0; n < 600; n++)
         cycle(($urandom_range(0, 1) == 1), CFG_W'($urandom),
               ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 3),
               ($urandom_range(0, 49) == 0));

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule

// File: doc/hci_streamer_sequencer.md
HCI_STREAMER_SEQUENCER -- requirements
Module: hci_streamer_sequencer

Interface
REQ-001 SHALL have parameter JOB_DEPTH, default 2: job FIFO entries; power of two, >=2.
REQ-002 SHALL have parameter CNT_W, default 16: width of the completed-job counter.
REQ-003 SHALL have port clk_i  input  1  the block's single clock; all state on rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port clear_i  input  1  synchronous clear, active-high.
REQ-006 SHALL have port job_valid_i  input  1  job push request.
REQ-007 SHALL have port job_ready_o  output  1  job FIFO can accept.
REQ-008 SHALL have port job_cfg_i  input  hwpe_stream_package::ctrl_addressgen_v3_t  address-generator configuration of the pushed job.
REQ-009 SHALL have port ctrl_o  output  hci_package::hci_streamer_ctrl_t  streamer control (req_start, addressgen_ctrl).
REQ-010 SHALL have port flags_i  input  hci_package::hci_streamer_flags_t  streamer flags (ready_start, done, addressgen_flags).
REQ-011 SHALL have port state_o  output  hci_package::hci_streamer_state_t  sequencer FSM state.
REQ-012 SHALL have port evt_done_o  output  1  one-cycle pulse per completed job.
REQ-013 SHALL have port jobs_pending_o  output  $clog2(JOB_DEPTH+1)  FIFO occupancy.
REQ-014 SHALL have port jobs_done_o  output  CNT_W  completed-job count.

Function
REQ-015 SHALL store jobs in a JOB_DEPTH-entry FIFO; push iff job_valid_i && job_ready_o; job_ready_o = !full (no bypass, even when a pop occurs that cycle).
REQ-016 SHALL implement FSM STREAMER_IDLE -> STREAMER_WORKING -> STREAMER_DONE -> STREAMER_IDLE; state_o = current state.
REQ-017 In IDLE SHALL drive ctrl_o.req_start = !empty && flags_i.ready_start && !clear_i (combinational), and ctrl_o.addressgen_ctrl = FIFO head (all-zero when empty).
REQ-018 On req_start SHALL pop the FIFO head, latch it as the in-flight config, and move to WORKING next cycle.
REQ-019 In WORKING and DONE SHALL hold ctrl_o.addressgen_ctrl stable at the latched config and ctrl_o.req_start = 0.
REQ-020 In WORKING SHALL go to DONE on the cycle after flags_i.done = 1; flags_i.done in IDLE, in DONE, or in the req_start cycle SHALL be ignored.
REQ-021 DONE SHALL last exactly one cycle: evt_done_o = 1, jobs_done_o increments (wraps 2^CNT_W-1 -> 0), next state IDLE.
REQ-022 Issue latency: job pushed at edge t into an empty FIFO with FSM IDLE and ready_start = 1 SHALL see req_start = 1 during cycle t+1.
REQ-023 Back-to-back: minimum spacing between consecutive req_start pulses SHALL be 3 cycles (issue, >=1 WORKING, DONE, then IDLE issue).
REQ-024 A push and a pop in the same cycle SHALL leave jobs_pending_o unchanged; pointers wrap modulo JOB_DEPTH.
REQ-025 flags_i.addressgen_flags SHALL be ignored.

Reset
REQ-026 On rst_ni = 0 (asynchronous) or clear_i = 1 (next edge) SHALL: FIFO empty, state IDLE, latched config 0, jobs_done_o = 0, evt_done_o = 0, ctrl_o = 0; job_ready_o = 1 after clearing; clear_i has priority over any push, issue, or done in the same cycle.
REQ-027 Reset or clear in WORKING SHALL abandon the in-flight job with no evt_done_o and no jobs_done_o increment.

Verification
REQ-028 Single job: push cfg A with ready_start = 1 -> req_start in the next cycle with addressgen_ctrl = A; done 5 cycles later -> DONE for 1 cycle, evt_done_o = 1, jobs_done_o = 1, then IDLE.
REQ-029 Full FIFO (JOB_DEPTH = 2): push A, B with ready_start = 0 -> job_ready_o = 0, jobs_pending_o = 2; a third push is refused; raise ready_start -> A issued, then B after A's done.
REQ-030 Stall: ready_start = 0 for 10 cycles with a job pending -> no req_start, state IDLE, jobs_pending_o = 1.
REQ-031 Spurious done: done pulses in IDLE and in the req_start cycle -> no transition and no evt_done_o.
REQ-032 Mid-job clear: clear_i in WORKING with 1 job queued -> next cycle IDLE, jobs_pending_o = 0, jobs_done_o = 0, no evt_done_o; repeat with async rst_ni -> same result, immediately.
REQ-033 Counter wrap (CNT_W = 2): complete 4 jobs -> jobs_done_o = 1, 2, 3, 0.
